multicycle_controller: RTL and testbench
========================================

# multicycle_controller

Multi-cycle control FSM for the RISC-V core. It replaces single-cycle opcode decoding with a five-stage instruction sequence: fetch, decode, execute, memory, write-back. It stalls on variable-latency instruction and data memories via ready inputs, drives the same datapath control signals stage by stage, flags illegal opcodes, and counts retired instructions. It sits between the instruction register and the datapath: the datapath, register file, ALU control and both memories are driven from it.

## Interface
Parameters:
- CNT_W, 32, width of the retired-instruction counter

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high reset
- Opcode  in  7  opcode field from the instruction register, valid from DECODE onward
- imem_ready  in  1  instruction memory has valid data (sampled in FETCH only)
- dmem_ready  in  1  data memory access complete (sampled in MEM only)
- IRWrite  out  1  load instruction register
- PCWrite  out  1  update PC (datapath selects PC+4 or the branch target using Branch & Zero)
- ALUSrc  out  1  0: rs2; 1: immediate
- MemtoReg  out  1  write-back source; 1: data memory
- RegWrite  out  1  register file write enable
- MemRead  out  1  data memory read request
- MemWrite  out  1  data memory write request
- ALUOp  out  2  00: LW/SW; 01: branch; 10: R/I-type; 11: U-type
- Branch  out  1  instruction is a conditional branch
- Illegal  out  1  sticky illegal-opcode flag
- state  out  3  current FSM state, for debug
- retired  out  CNT_W  retired-instruction count

## Operation
- Opcodes:
  - LUI 0110111
  - I-type 0010011
  - R-type 0110011
  - LW 0000011
  - SW 0100011
  - BEQ 1100011
  - Any other value is illegal.
- State encoding: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, TRAP=5.
- The Opcode input is latched into op_q on the DECODE→EXEC transition. All later decoding uses op_q.
- FETCH: IRWrite = imem_ready. Go to DECODE when imem_ready=1, otherwise stay.
- DECODE: all outputs 0. Illegal opcode → TRAP; otherwise → EXEC.
- EXEC:
  - ALUSrc=1 for LW, SW, I-type and LUI.
  - ALUOp per the encoding above.
  - BEQ: Branch=1, PCWrite=1, retire, → FETCH.
  - LW/SW: → MEM.
  - R/I/U: → WB.
- MEM:
  - ALUSrc and ALUOp are held.
  - MemRead=1 (LW) or MemWrite=1 (SW), held continuously until dmem_ready=1.
  - On dmem_ready: SW → PCWrite=1, retire, → FETCH; LW → WB.
- WB:
  - ALUSrc and ALUOp are held.
  - RegWrite=1; MemtoReg=1 for LW.
  - PCWrite=1, retire, → FETCH.
- TRAP: Illegal=1, all other outputs 0. TRAP is absorbing; only reset exits it.
- Outputs are combinational functions of state and op_q (plus imem_ready for IRWrite). There are no registered outputs.
- retired increments by 1 in every retire cycle and wraps modulo 2^CNT_W without a flag.
- An instruction that never reaches retire (trap, or reset mid-instruction) is not counted.

## Timing
- Reset (asynchronous):
  - state=FETCH, op_q=0, retired=0, Illegal=0.
  - While reset is high, every control output is forced to 0, including IRWrite.
- Reset asserted mid-instruction aborts it immediately. No PCWrite, RegWrite or memory strobe reaches the clock edge after reset is asserted.
- Zero-wait latency, FETCH to retire cycle inclusive:
  - BEQ: 3 cycles
  - R/I/U: 4 cycles
  - SW: 4 cycles
  - LW: 5 cycles
- Each cycle imem_ready or dmem_ready is low adds exactly one cycle.
- The ready inputs are ignored outside their sampling state.
- PCWrite is high for exactly one cycle per retired instruction. RegWrite is high only in WB.
- MemRead and MemWrite are never high together.

## Structure
- Shared package riscv_ctrl_pkg holds:
  - opcode localparams
  - the state_t enum (3-bit)
  - ALUOp encoding constants
- The package is shared with the existing single-cycle decoder.
- One sub-module, opcode_classifier: combinational op_q → {is_r, is_i, is_u, is_lw, is_sw, is_br, legal}. The FSM instantiates it twice, on Opcode for the DECODE legality check and on op_q for output decoding.

## Test plan
- R-type add (0110011), readies tied high → state sequence 0,1,2,4,0; RegWrite high only in cycle 4; ALUOp=10 in cycles 3–4; retired 0→1.
- LW with dmem_ready low for 2 MEM cycles → MemRead high 3 consecutive cycles; WB has MemtoReg=1 and RegWrite=1; total 7 cycles; retired +1.
- BEQ (1100011) → 3 cycles; EXEC has Branch=1, ALUOp=01, PCWrite=1; RegWrite never high.
- Opcode 1111111 → TRAP after DECODE; Illegal=1 stays set over 100 cycles; retired unchanged; reset returns state=0 and Illegal=0.
- Reset asserted asynchronously mid-MEM of SW → MemWrite drops within the same cycle; state=FETCH, retired=0.
- CNT_W=4, 17 BEQs back-to-back → retired reads 1 after the 17th instruction (wrap at 16).

Source files
------------

// File: rtl/riscv_ctrl_pkg.sv
// rtl/riscv_ctrl_pkg.sv - opcodes, FSM states and ALUOp encodings shared by the RISC-V control logic
package riscv_ctrl_pkg;

    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_ITYPE = 7'b0010011;
    localparam logic [6:0] OP_RTYPE = 7'b0110011;
    localparam logic [6:0] OP_LW    = 7'b0000011;
    localparam logic [6:0] OP_SW    = 7'b0100011;
    localparam logic [6:0] OP_BEQ   = 7'b1100011;

    localparam logic [1:0] ALUOP_MEM = 2'b00;
    localparam logic [1:0] ALUOP_BR  = 2'b01;
    localparam logic [1:0] ALUOP_RI  = 2'b10;
    localparam logic [1:0] ALUOP_U   = 2'b11;

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_TRAP   = 3'd5
    } state_t;

    typedef struct packed {
        logic is_r;
        logic is_i;
        logic is_u;
        logic is_lw;
        logic is_sw;
        logic is_br;
        logic legal;
    } op_class_t;

    function automatic logic [1:0] alu_op_of(input op_class_t c);
        if (c.is_br)
            return ALUOP_BR;
        else if (c.is_u)
            return ALUOP_U;
        else if (c.is_r || c.is_i)
            return ALUOP_RI;
        else
            return ALUOP_MEM;
    endfunction

    function automatic logic alu_src_of(input op_class_t c);
        return c.is_lw | c.is_sw | c.is_i | c.is_u;
    endfunction

endpackage

// File: rtl/multicycle_controller_if.sv
// rtl/multicycle_controller_if.sv - opcode, memory-ready and datapath control bundle of the multicycle controller
interface multicycle_controller_if #(
    parameter int CNT_W = 32
);
    logic [6:0]       Opcode;
    logic             imem_ready;
    logic             dmem_ready;
    logic             IRWrite;
    logic             PCWrite;
    logic             ALUSrc;
    logic             MemtoReg;
    logic             RegWrite;
    logic             MemRead;
    logic             MemWrite;
    logic [1:0]       ALUOp;
    logic             Branch;
    logic             Illegal;
    logic [2:0]       state;
    logic [CNT_W-1:0] retired;

    modport master (
        input  Opcode, imem_ready, dmem_ready,
        output IRWrite, PCWrite, ALUSrc, MemtoReg, RegWrite, MemRead, MemWrite,
               ALUOp, Branch, Illegal, state, retired
    );

    modport slave (
        output Opcode, imem_ready, dmem_ready,
        input  IRWrite, PCWrite, ALUSrc, MemtoReg, RegWrite, MemRead, MemWrite,
               ALUOp, Branch, Illegal, state, retired
    );
endinterface

// File: rtl/opcode_classifier.sv
// rtl/opcode_classifier.sv - combinational opcode to instruction-class decode
module opcode_classifier
    import riscv_ctrl_pkg::*;
(
    input  logic [6:0] i_opcode,
    output op_class_t  o_class
);
    always_comb begin
        o_class       = '0;
        o_class.is_r  = (i_opcode == OP_RTYPE);
        o_class.is_i  = (i_opcode == OP_ITYPE);
        o_class.is_u  = (i_opcode == OP_LUI);
        o_class.is_lw = (i_opcode == OP_LW);
        o_class.is_sw = (i_opcode == OP_SW);
        o_class.is_br = (i_opcode == OP_BEQ);
        o_class.legal = o_class.is_r | o_class.is_i | o_class.is_u |
                        o_class.is_lw | o_class.is_sw | o_class.is_br;
    end
endmodule

// File: rtl/multicycle_controller.sv
// rtl/multicycle_controller.sv - five-stage multicycle control FSM with memory stalls, illegal trap and retire counter
module multicycle_controller
    import riscv_ctrl_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    multicycle_controller_if.master bus
);
    state_t           r_state;
    logic [6:0]       r_op_q;
    logic [CNT_W-1:0] r_retired;

    op_class_t  w_cls_in;
    op_class_t  w_cls_q;
    logic       w_irwrite, w_pcwrite, w_alusrc, w_memtoreg, w_regwrite;
    logic       w_memread, w_memwrite, w_branch, w_illegal;
    logic [1:0] w_aluop;

    opcode_classifier u_cls_in (.i_opcode(bus.Opcode), .o_class(w_cls_in));
    opcode_classifier u_cls_q  (.i_opcode(r_op_q),     .o_class(w_cls_q));

    // Gating with reset keeps IRWrite (fed straight from imem_ready) low during reset too.
    always_comb begin
        w_irwrite  = 1'b0;
        w_pcwrite  = 1'b0;
        w_alusrc   = 1'b0;
        w_memtoreg = 1'b0;
        w_regwrite = 1'b0;
        w_memread  = 1'b0;
        w_memwrite = 1'b0;
        w_branch   = 1'b0;
        w_illegal  = 1'b0;
        w_aluop    = ALUOP_MEM;
        if (!reset) begin
            case (r_state)
                S_FETCH: w_irwrite = bus.imem_ready;
                S_EXEC: begin
                    w_alusrc  = alu_src_of(w_cls_q);
                    w_aluop   = alu_op_of(w_cls_q);
                    w_branch  = w_cls_q.is_br;
                    w_pcwrite = w_cls_q.is_br;
                end
                S_MEM: begin
                    w_alusrc   = alu_src_of(w_cls_q);
                    w_aluop    = alu_op_of(w_cls_q);
                    w_memread  = w_cls_q.is_lw;
                    w_memwrite = w_cls_q.is_sw;
                    w_pcwrite  = w_cls_q.is_sw & bus.dmem_ready;
                end
                S_WB: begin
                    w_alusrc   = alu_src_of(w_cls_q);
                    w_aluop    = alu_op_of(w_cls_q);
                    w_regwrite = 1'b1;
                    w_memtoreg = w_cls_q.is_lw;
                    w_pcwrite  = 1'b1;
                end
                S_TRAP: w_illegal = 1'b1;
                default: ;
            endcase
        end
    end

    // PCWrite marks the retire cycle of every instruction.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= S_FETCH;
            r_op_q    <= '0;
            r_retired <= '0;
        end else begin
            if (w_pcwrite)
                r_retired <= r_retired + CNT_W'(1);
            case (r_state)
                S_FETCH:
                    if (bus.imem_ready)
                        r_state <= S_DECODE;
                S_DECODE:
                    if (!w_cls_in.legal)
                        r_state <= S_TRAP;
                    else begin
                        r_op_q  <= bus.Opcode;
                        r_state <= S_EXEC;
                    end
                S_EXEC:
                    if (w_cls_q.is_br)
                        r_state <= S_FETCH;
                    else if (w_cls_q.is_lw || w_cls_q.is_sw)
                        r_state <= S_MEM;
                    else
                        r_state <= S_WB;
                S_MEM:
                    if (bus.dmem_ready)
                        r_state <= w_cls_q.is_sw ? S_FETCH : S_WB;
                S_WB:    r_state <= S_FETCH;
                S_TRAP:  r_state <= S_TRAP;
                default: r_state <= S_FETCH;
            endcase
        end
    end

    assign bus.IRWrite  = w_irwrite;
    assign bus.PCWrite  = w_pcwrite;
    assign bus.ALUSrc   = w_alusrc;
    assign bus.MemtoReg = w_memtoreg;
    assign bus.RegWrite = w_regwrite;
    assign bus.MemRead  = w_memread;
    assign bus.MemWrite = w_memwrite;
    assign bus.ALUOp    = w_aluop;
    assign bus.Branch   = w_branch;
    assign bus.Illegal  = w_illegal;
    assign bus.state    = r_state;
    assign bus.retired  = r_retired;
endmodule

// File: tb/tb_multicycle_controller.sv
// tb/tb_multicycle_controller.sv - scoreboard bench for multicycle_controller with directed instruction sequences
module tb_multicycle_controller;
    localparam int CW = 4;

    localparam logic [6:0] R_OP   = 7'b0110011;
    localparam logic [6:0] I_OP   = 7'b0010011;
    localparam logic [6:0] LUI_OP = 7'b0110111;
    localparam logic [6:0] LW_OP  = 7'b0000011;
    localparam logic [6:0] SW_OP  = 7'b0100011;
    localparam logic [6:0] BEQ_OP = 7'b1100011;
    localparam logic [6:0] BAD_OP = 7'b1111111;

    logic clk;
    logic reset;

    multicycle_controller_if #(.CNT_W(CW)) bus ();

    multicycle_controller #(.CNT_W(CW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int          id;
        logic [2:0]  st;
        logic [10:0] ctrl;
        logic [CW-1:0] ret;
    } exp_t;

    exp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;
    int   step_id  = 0;

    // ctrl bit order: IRWrite PCWrite ALUSrc MemtoReg RegWrite MemRead MemWrite ALUOp[1:0] Branch Illegal
    function automatic logic [10:0] cw(input logic ir, pc, src, m2r, rw, mr, mw,
                                       input logic [1:0] aop, input logic br, ill);
        return {ir, pc, src, m2r, rw, mr, mw, aop, br, ill};
    endfunction

    task automatic step(input logic rst_v, input logic [6:0] op, input logic im, input logic dm,
                        input logic [2:0] st, input logic [10:0] c, input int ret);
        exp_t e;
        @(posedge clk);
        #1;
        reset          = rst_v;
        bus.Opcode     = op;
        bus.imem_ready = im;
        bus.dmem_ready = dm;
        e.id   = step_id;
        e.st   = st;
        e.ctrl = c;
        e.ret  = CW'(ret);
        exp_q.push_back(e);
        step_id++;
    endtask

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            logic [10:0] act;
            e   = exp_q.pop_front();
            act = {bus.IRWrite, bus.PCWrite, bus.ALUSrc, bus.MemtoReg, bus.RegWrite,
                   bus.MemRead, bus.MemWrite, bus.ALUOp, bus.Branch, bus.Illegal};
            checks++;
            if (bus.state !== e.st || act !== e.ctrl || bus.retired !== e.ret) begin
                failures++;
                $display("FAIL step%0d got st=%0d ctrl=%b ret=%0d want st=%0d ctrl=%b ret=%0d",
                         e.id, bus.state, act, bus.retired, e.st, e.ctrl, e.ret);
            end
        end
    end

    localparam logic [10:0] Z = 11'b0;

    initial begin
        reset          = 1'b1;
        bus.Opcode     = '0;
        bus.imem_ready = 1'b0;
        bus.dmem_ready = 1'b0;

        // reset holds IRWrite low even with imem_ready high
        step(1, R_OP, 1, 1, 0, Z, 0);

        // R-type, dmem_ready low throughout to show it is ignored
        step(0, R_OP, 1, 0, 0, cw(1,0,0,0,0,0,0,2'b00,0,0), 0);
        step(0, R_OP, 0, 0, 1, Z, 0);
        step(0, R_OP, 0, 0, 2, cw(0,0,0,0,0,0,0,2'b10,0,0), 0);
        step(0, R_OP, 0, 0, 4, cw(0,1,0,0,1,0,0,2'b10,0,0), 0);

        // LW with two data-memory wait cycles
        step(0, LW_OP, 1, 1, 0, cw(1,0,0,0,0,0,0,2'b00,0,0), 1);
        step(0, LW_OP, 1, 1, 1, Z, 1);
        step(0, LW_OP, 1, 1, 2, cw(0,0,1,0,0,0,0,2'b00,0,0), 1);
        step(0, LW_OP, 1, 0, 3, cw(0,0,1,0,0,1,0,2'b00,0,0), 1);
        step(0, LW_OP, 1, 0, 3, cw(0,0,1,0,0,1,0,2'b00,0,0), 1);
        step(0, LW_OP, 1, 1, 3, cw(0,0,1,0,0,1,0,2'b00,0,0), 1);
        step(0, LW_OP, 1, 1, 4, cw(0,1,1,1,1,0,0,2'b00,0,0), 1);

        // BEQ
        step(0, BEQ_OP, 1, 1, 0, cw(1,0,0,0,0,0,0,2'b00,0,0), 2);
        step(0, BEQ_OP, 1, 1, 1, Z, 2);
        step(0, BEQ_OP, 1, 1, 2, cw(0,1,0,0,0,0,0,2'b01,1,0), 2);

        // SW with one instruction-memory wait cycle
        step(0, SW_OP, 0, 1, 0, Z, 3);
        step(0, SW_OP, 1, 1, 0, cw(1,0,0,0,0,0,0,2'b00,0,0), 3);
        step(0, SW_OP, 0, 1, 1, Z, 3);
        step(0, SW_OP, 0, 1, 2, cw(0,0,1,0,0,0,0,2'b00,0,0), 3);
        step(0, SW_OP, 0, 1, 3, cw(0,1,1,0,0,0,1,2'b00,0,0), 3);

        // I-type then LUI
        step(0, I_OP, 1, 1, 0, cw(1,0,0,0,0,0,0,2'b00,0,0), 4);
        step(0, I_OP, 1, 1, 1, Z, 4);
        step(0, I_OP, 1, 1, 2, cw(0,0,1,0,0,0,0,2'b10,0,0), 4);
        step(0, I_OP, 1, 1, 4, cw(0,1,1,0,1,0,0,2'b10,0,0), 4);
        step(0, LUI_OP, 1, 1, 0, cw(1,0,0,0,0,0,0,2'b00,0,0), 5);
        step(0, LUI_OP, 1, 1, 1, Z, 5);
        step(0, LUI_OP, 1, 1, 2, cw(0,0,1,0,0,0,0,2'b11,0,0), 5);
        step(0, LUI_OP, 1, 1, 4, cw(0,1,1,0,1,0,0,2'b11,0,0), 5);

        // illegal opcode traps and stays trapped
        step(0, BAD_OP, 1, 1, 0, cw(1,0,0,0,0,0,0,2'b00,0,0), 6);
        step(0, BAD_OP, 1, 1, 1, Z, 6);
        for (int i = 0; i < 100; i++)
            step(0, (i % 2 == 0) ? R_OP : BEQ_OP, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 5, cw(0,0,0,0,0,0,0,2'b00,0,1), 6);
        step(1, R_OP, 1, 1, 0, Z, 0);

        // SW aborted by reset while stalled in MEM
        step(0, SW_OP, 1, 0, 0, cw(1,0,0,0,0,0,0,2'b00,0,0), 0);
        step(0, SW_OP, 1, 0, 1, Z, 0);
        step(0, SW_OP, 1, 0, 2, cw(0,0,1,0,0,0,0,2'b00,0,0), 0);
        step(0, SW_OP, 1, 0, 3, cw(0,0,1,0,0,0,1,2'b00,0,0), 0);
        step(1, SW_OP, 1, 0, 0, Z, 0);

        // 17 back-to-back BEQs wrap the 4-bit counter
        for (int k = 0; k < 17; k++) begin
            step(0, BEQ_OP, 1, 1, 0, cw(1,0,0,0,0,0,0,2'b00,0,0), k % 16);
            step(0, BEQ_OP, 1, 1, 1, Z, k % 16);
            step(0, BEQ_OP, 1, 1, 2, cw(0,1,0,0,0,0,0,2'b01,1,0), k % 16);
        end
        step(0, BEQ_OP, 0, 1, 0, Z, 1);

        repeat (3) @(posedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL drain got pending=%0d want pending=0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
